// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side bus of the memory-stage SRAM controller: request operands from
// EXE/MEM, load data back to MEM/WB, and the low-active freeze (ready).
interface mem_sram_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output rd_en, wr_en, address, wdata, input rdata, ready);
    modport slave  (input rd_en, wr_en, address, wdata, output rdata, ready);
endinterface

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two timed
// half-word accesses on a 16-bit asynchronous SRAM, freezing the pipeline meanwhile.
module mem_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    mem_sram_ctrl_if.slave     bus,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [15:0]        o_sram_dq_out,
    output logic               o_sram_dq_oe,
    input  logic [15:0]        i_sram_dq_in,
    output logic               o_sram_we_n
);
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    localparam int         IDX_W   = SRAM_AW - 1;
    localparam logic [2:0] LP_LAST = 3'(WAIT_CYCLES);

    state_t             r_state;
    state_t             w_next_state;
    logic [2:0]         r_count;
    logic               r_is_write;
    logic [IDX_W-1:0]   r_word_idx;
    logic [31:0]        r_wdata;
    logic [15:0]        r_rdata_lo;
    logic [31:0]        r_rdata;
    logic [SRAM_AW-1:0] r_addr_hold;

    logic               w_req;
    logic               w_in_phase;
    logic               w_phase_end;
    logic [IDX_W-1:0]   w_word_idx;

    assign w_req       = bus.rd_en | bus.wr_en;
    assign w_in_phase  = (r_state == S_LOW) || (r_state == S_HIGH);
    assign w_phase_end = (r_count == LP_LAST);
    // Addresses below BASE_ADDR wrap through the modulo of the truncation.
    assign w_word_idx  = IDX_W'((bus.address - 32'(BASE_ADDR)) >> 2);
    assign bus.rdata   = r_rdata;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_next_state  = r_state;
        bus.ready     = 1'b0;
        o_sram_addr   = r_addr_hold;
        o_sram_dq_out = 16'h0000;
        o_sram_dq_oe  = 1'b0;
        o_sram_we_n   = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.ready = !w_req;
                if (w_req) w_next_state = S_LOW;
            end
            S_LOW: begin
                o_sram_addr = {r_word_idx, 1'b0};
                if (r_is_write) begin
                    o_sram_dq_out = r_wdata[15:0];
                    o_sram_dq_oe  = 1'b1;
                    o_sram_we_n   = 1'b0;
                end
                if (w_phase_end) w_next_state = S_HIGH;
            end
            S_HIGH: begin
                o_sram_addr = {r_word_idx, 1'b1};
                if (r_is_write) begin
                    o_sram_dq_out = r_wdata[31:16];
                    o_sram_dq_oe  = 1'b1;
                    o_sram_we_n   = 1'b0;
                end
                if (w_phase_end) w_next_state = S_DONE;
            end
            S_DONE: begin
                bus.ready    = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= 3'd0;
            r_is_write  <= 1'b0;
            r_word_idx  <= '0;
            r_wdata     <= 32'h0;
            r_rdata_lo  <= 16'h0;
            r_rdata     <= 32'h0;
            r_addr_hold <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state || !w_in_phase) begin
                r_count <= 3'd0;
            end else begin
                r_count <= r_count + 3'd1;
            end

            // Operands are captured once so upstream changes mid-access are ignored.
            if (r_state == S_IDLE && w_req) begin
                r_is_write <= bus.wr_en;
                r_word_idx <= w_word_idx;
                r_wdata    <= bus.wdata;
            end

            if (w_in_phase) r_addr_hold <= o_sram_addr;

            if (!r_is_write && w_phase_end) begin
                if (r_state == S_LOW)  r_rdata_lo <= i_sram_dq_in;
                if (r_state == S_HIGH) r_rdata    <= {i_sram_dq_in, r_rdata_lo};
            end
        end
    end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: two instances (WAIT_CYCLES=1 and 0) on SRAM models,
// checked every cycle against a transaction-schedule model plus literal expectations.
module tb_mem_sram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Index 0: WAIT_CYCLES=1 instance, index 1: WAIT_CYCLES=0 instance.
    logic        s_rd[2];
    logic        s_wr[2];
    logic [31:0] s_address[2];
    logic [31:0] s_wdata[2];
    logic [31:0] s_rdata[2];
    logic        s_ready[2];
    logic [17:0] s_addr[2];
    logic [15:0] s_dq_out[2];
    logic        s_oe[2];
    logic        s_we_n[2];

    logic [17:0] addr_a, addr_b;
    logic [15:0] dq_out_a, dq_out_b, dq_in_a, dq_in_b;
    logic        oe_a, oe_b, we_n_a, we_n_b;

    bit [15:0] sram_hw [2][262144];

    mem_sram_ctrl_if bus_a();
    mem_sram_ctrl_if bus_b();

    assign bus_a.rd_en   = s_rd[0];
    assign bus_a.wr_en   = s_wr[0];
    assign bus_a.address = s_address[0];
    assign bus_a.wdata   = s_wdata[0];
    assign bus_b.rd_en   = s_rd[1];
    assign bus_b.wr_en   = s_wr[1];
    assign bus_b.address = s_address[1];
    assign bus_b.wdata   = s_wdata[1];

    mem_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024), .SRAM_AW(18)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_a),
        .o_sram_addr  (addr_a),
        .o_sram_dq_out(dq_out_a),
        .o_sram_dq_oe (oe_a),
        .i_sram_dq_in (dq_in_a),
        .o_sram_we_n  (we_n_a)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(1024), .SRAM_AW(18)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_b),
        .o_sram_addr  (addr_b),
        .o_sram_dq_out(dq_out_b),
        .o_sram_dq_oe (oe_b),
        .i_sram_dq_in (dq_in_b),
        .o_sram_we_n  (we_n_b)
    );

    assign s_rdata[0]  = bus_a.rdata;
    assign s_ready[0]  = bus_a.ready;
    assign s_addr[0]   = addr_a;
    assign s_dq_out[0] = dq_out_a;
    assign s_oe[0]     = oe_a;
    assign s_we_n[0]   = we_n_a;
    assign s_rdata[1]  = bus_b.rdata;
    assign s_ready[1]  = bus_b.ready;
    assign s_addr[1]   = addr_b;
    assign s_dq_out[1] = dq_out_b;
    assign s_oe[1]     = oe_b;
    assign s_we_n[1]   = we_n_b;

    // Asynchronous SRAM models: combinational read, write while we_n is low.
    assign dq_in_a = sram_hw[0][addr_a];
    assign dq_in_b = sram_hw[1][addr_b];
    always @(posedge clk) begin
        if (!we_n_a) sram_hw[0][addr_a] <= dq_out_a;
        if (!we_n_b) sram_hw[1][addr_b] <= dq_out_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted request is a fixed schedule of cycles
    // (request cycle, low phase, high phase, one ready cycle).
    int          m_pos[2]       = '{-1, -1};
    bit          m_wr[2];
    logic [16:0] m_idx[2];
    logic [31:0] m_wdata[2];
    logic [31:0] m_rdata[2]     = '{32'h0, 32'h0};
    logic [17:0] m_last_addr[2] = '{18'h0, 18'h0};
    bit   [15:0] m_mem [2][262144];

    function automatic logic [16:0] word_index(input logic [31:0] a);
        return 17'((a - 32'd1024) >> 2);
    endfunction

    task automatic compare_dut(input int d);
        int          ph;
        int          p;
        bit          in_lo, in_hi, strobe;
        logic [17:0] exp_addr;
        logic [15:0] half;
        ph = (d == 0) ? 2 : 1;
        if (rst) begin
            m_pos[d]       = -1;
            m_rdata[d]     = 32'h0;
            m_last_addr[d] = 18'h0;
            check($sformatf("rst_ready[%0d]", d), 32'(s_ready[d]), 32'(!(s_rd[d] || s_wr[d])));
            check($sformatf("rst_we_n[%0d]", d), 32'(s_we_n[d]), 32'd1);
            check($sformatf("rst_oe[%0d]", d), 32'(s_oe[d]), 32'd0);
            check($sformatf("rst_addr[%0d]", d), 32'(s_addr[d]), 32'd0);
            check($sformatf("rst_rdata[%0d]", d), s_rdata[d], 32'h0);
            return;
        end
        if (m_pos[d] < 0 && (s_rd[d] || s_wr[d])) begin
            m_pos[d]   = 0;
            m_wr[d]    = s_wr[d];
            m_idx[d]   = word_index(s_address[d]);
            m_wdata[d] = s_wdata[d];
        end
        p        = m_pos[d];
        in_lo    = (p >= 1) && (p <= ph);
        in_hi    = (p > ph) && (p <= 2 * ph);
        strobe   = (in_lo || in_hi) && m_wr[d];
        exp_addr = m_last_addr[d];
        if (in_lo) exp_addr = {m_idx[d], 1'b0};
        if (in_hi) exp_addr = {m_idx[d], 1'b1};
        half = in_hi ? m_wdata[d][31:16] : m_wdata[d][15:0];
        if (p == 2 * ph + 1 && !m_wr[d])
            m_rdata[d] = {m_mem[d][{m_idx[d], 1'b1}], m_mem[d][{m_idx[d], 1'b0}]};

        check($sformatf("ready[%0d]", d), 32'(s_ready[d]), 32'((p < 0) || (p == 2 * ph + 1)));
        check($sformatf("sram_addr[%0d]", d), 32'(s_addr[d]), 32'(exp_addr));
        check($sformatf("we_n[%0d]", d), 32'(s_we_n[d]), 32'(!strobe));
        check($sformatf("oe[%0d]", d), 32'(s_oe[d]), 32'(strobe));
        check($sformatf("rdata[%0d]", d), s_rdata[d], m_rdata[d]);
        if (strobe) begin
            check($sformatf("dq_out[%0d]", d), 32'(s_dq_out[d]), 32'(half));
            m_mem[d][exp_addr] = half;
        end

        m_last_addr[d] = exp_addr;
        if (p >= 0) m_pos[d] = (p == 2 * ph + 1) ? -1 : p + 1;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) compare_dut(d);
    end

    logic [17:0] log_addr[$];
    logic        log_we_n[$];
    logic [15:0] log_dq[$];
    logic [31:0] done_rdata;

    // Presents one request and holds it until the ready cycle, logging the bus
    // on every frozen cycle; returns the number of frozen cycles.
    task automatic run_req(input int d, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd, output int low);
        low = 0;
        log_addr.delete();
        log_we_n.delete();
        log_dq.delete();
        s_rd[d] = rd;
        s_wr[d] = wr;
        s_address[d] = addr;
        s_wdata[d] = wd;
        forever begin
            @(negedge clk);
            if (s_ready[d]) begin
                done_rdata = s_rdata[d];
                break;
            end
            low++;
            log_addr.push_back(s_addr[d]);
            log_we_n.push_back(s_we_n[d]);
            log_dq.push_back(s_dq_out[d]);
            if (low > 40) begin
                n_checks++;
                n_err++;
                $display("FAIL ready_timeout[%0d]: no ready after %0d cycles, expected at most 17", d, low);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_rd[d] = 1'b0;
        s_wr[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int low;
        int total;
        for (int d = 0; d < 2; d++) begin
            s_rd[d] = 1'b0;
            s_wr[d] = 1'b0;
            s_address[d] = 32'h0;
            s_wdata[d] = 32'h0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(s_ready[0]), 32'd1);
        check("reset_we_n", 32'(s_we_n[0]), 32'd1);
        check("reset_oe", 32'(s_oe[0]), 32'd0);
        check("reset_addr", 32'(s_addr[0]), 32'd0);
        check("reset_dq_out", 32'(s_dq_out[0]), 32'd0);
        check("reset_rdata", s_rdata[0], 32'h0);
        #2 rst = 1'b0;
        idle(2);

        // Write 0xDEADBEEF at byte 1032 -> half-words 4 and 5.
        run_req(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, low);
        check("t1_low_cycles", 32'(low), 32'd5);
        check("t1_req_we_n", 32'(log_we_n[0]), 32'd1);
        check("t1_lo_addr0", 32'(log_addr[1]), 32'd4);
        check("t1_lo_dq0", 32'(log_dq[1]), 32'hBEEF);
        check("t1_lo_we_n0", 32'(log_we_n[1]), 32'd0);
        check("t1_lo_addr1", 32'(log_addr[2]), 32'd4);
        check("t1_lo_we_n1", 32'(log_we_n[2]), 32'd0);
        check("t1_hi_addr0", 32'(log_addr[3]), 32'd5);
        check("t1_hi_dq0", 32'(log_dq[3]), 32'hDEAD);
        check("t1_hi_addr1", 32'(log_addr[4]), 32'd5);
        check("t1_hi_we_n1", 32'(log_we_n[4]), 32'd0);

        // Read it back; rdata must hold through idle cycles.
        run_req(0, 1'b1, 1'b0, 32'd1032, 32'h0, low);
        check("t2_low_cycles", 32'(low), 32'd5);
        check("t2_done_rdata", done_rdata, 32'hDEADBEEF);
        idle(10);
        check("t2_rdata_held", s_rdata[0], 32'hDEADBEEF);

        // Both requests asserted: the write wins.
        run_req(0, 1'b1, 1'b1, 32'd1024, 32'h12345678, low);
        check("t3_rdata_kept", s_rdata[0], 32'hDEADBEEF);
        check("t3_sram_lo", 32'(sram_hw[0][0]), 32'h5678);
        check("t3_sram_hi", 32'(sram_hw[0][1]), 32'h1234);

        // Back-to-back: read, then a write in the very next idle cycle.
        run_req(0, 1'b1, 1'b0, 32'd1024, 32'h0, low);
        total = low + 1;
        check("t4_read_rdata", done_rdata, 32'h12345678);
        run_req(0, 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, low);
        total += low + 1;
        check("t4_total_cycles", 32'(total), 32'd12);
        run_req(0, 1'b1, 1'b0, 32'd1040, 32'h0, low);
        check("t4_readback", done_rdata, 32'hCAFEF00D);

        // Reset asserted between edges during the high phase of a write.
        s_wr[0] = 1'b1;
        s_address[0] = 32'd1032;
        s_wdata[0] = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #2;
        check("t5_in_high_addr", 32'(s_addr[0]), 32'd5);
        check("t5_in_high_we_n", 32'(s_we_n[0]), 32'd0);
        rst = 1'b1;
        s_wr[0] = 1'b0;
        #1;
        check("t5_rst_we_n", 32'(s_we_n[0]), 32'd1);
        check("t5_rst_oe", 32'(s_oe[0]), 32'd0);
        check("t5_rst_ready", 32'(s_ready[0]), 32'd1);
        check("t5_rst_rdata", s_rdata[0], 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        idle(2);
        check("t5_idle_ready", 32'(s_ready[0]), 32'd1);

        // Zero wait cycles, address below BASE_ADDR wraps to the top word.
        run_req(1, 1'b0, 1'b1, 32'd1020, 32'h5A5AA5A5, low);
        check("t6_wr_low_cycles", 32'(low), 32'd3);
        run_req(1, 1'b1, 1'b0, 32'd1020, 32'h0, low);
        check("t6_rd_low_cycles", 32'(low), 32'd3);
        check("t6_lo_addr", 32'(log_addr[1]), 32'h3FFFE);
        check("t6_hi_addr", 32'(log_addr[2]), 32'h3FFFF);
        check("t6_rdata", done_rdata, 32'h5A5AA5A5);

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "bench did not terminate");
    end
endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- Memory-stage controller between the EXE/MEM pipeline register and an external 16-bit asynchronous SRAM.
- Each 32-bit load or store issued by the MEM stage becomes two timed half-word SRAM accesses.
- Pipeline freeze is driven low-active through `ready`: while `ready`=0, all upstream stage registers hold their values.
- Store data and address come straight from the EXE/MEM register outputs. Load data returns to the MEM/WB register.

Parameters:
- WAIT_CYCLES, 1, extra hold cycles per half-word access. Each phase lasts WAIT_CYCLES+1 cycles. Legal range 0..7.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_en  in  1  load request (MEM_R_EN)
- wr_en  in  1  store request (MEM_W_EN)
- address  in  32  byte address (ALU result)
- wdata  in  32  store value (ST_val)
- rdata  out  32  last completed load value
- ready  out  1  1 = pipeline may advance; 0 = freeze
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_out  out  16  write data to SRAM
- sram_dq_oe  out  1  1 = controller drives DQ
- sram_dq_in  in  16  read data from SRAM
- sram_we_n  out  1  write enable, active-low

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset:
  - state=IDLE, counter=0, rdata=0
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0
  - ready=1 (only when no request is present)
  - Reset mid-operation aborts the access immediately. No partial rdata update.
- States: IDLE, LOW, HIGH, DONE. A phase counter, cleared on every state change, counts 0..WAIT_CYCLES.
- IDLE:
  - No request: stay in IDLE, ready=1.
  - rd_en or wr_en: latch op (write wins if both are asserted), address and wdata into internal registers; go to LOW. ready=0.
- LOW:
  - sram_addr = {word_idx, 1'b0}.
  - Write: sram_dq_out=wdata[15:0], oe=1, we_n=0 on every cycle of the phase.
  - Read: oe=0, we_n=1.
  - On counter==WAIT_CYCLES: a read captures sram_dq_in into rdata_lo; go to HIGH.
- HIGH: same as LOW, with sram_addr = {word_idx, 1'b1} and data wdata[31:16]. On the last cycle, a read writes rdata = {sram_dq_in, rdata_lo}; go to DONE.
- DONE:
  - ready=1, we_n=1, oe=0. Next state is IDLE unconditionally.
  - The pipeline advances on this edge, so the next request is sampled in the following IDLE cycle.
- `ready` is combinational from state and request: (IDLE && !rd_en && !wr_en) || DONE.
- Latency per request: ready is low for 1 + 2·(WAIT_CYCLES+1) cycles, then high for exactly 1 cycle (DONE).
- Address mapping:
  - word_idx = ((address − BASE_ADDR) >> 2)[SRAM_AW−2:0], modulo 2^(SRAM_AW−1).
  - Addresses below BASE_ADDR wrap; no error is flagged.
  - address[1:0] is ignored.
- Requests are sampled only in IDLE. Input changes during LOW/HIGH/DONE have no effect because the operands are latched.
- rdata holds its value across writes and idle cycles. It changes only at the end of a completed read.
- Never let we_n=0 with oe=0. In IDLE and DONE, sram_addr holds its last value.

Test Plan:
1. WAIT_CYCLES=1, wr_en=1, address=1032, wdata=0xDEADBEEF:
   - sram_addr=4 with dq_out=0xBEEF and we_n=0 for 2 cycles.
   - Then sram_addr=5 with 0xDEAD for 2 cycles.
   - ready low for 5 cycles, then high for 1.
2. Read back address=1032 with an SRAM model holding the scenario 1 data: rdata=0xDEADBEEF in the DONE cycle; rdata stays 0xDEADBEEF through 10 idle cycles.
3. rd_en=1 and wr_en=1 both asserted, address=1024, wdata=0x12345678: a write is performed (addresses 0/1 written), and rdata is unchanged.
4. Back-to-back: read held for one request, then a write immediately after DONE. The second request starts in the next IDLE cycle; total 12 cycles; no lost or duplicated access.
5. Assert rst during HIGH of a write: on the same edge/asynchronously, we_n=1, oe=0, ready=1, rdata=0. After release, an idle bus shows ready=1.
6. WAIT_CYCLES=0, read at address=1020: word_idx wraps to 0x1FFFF, giving sram_addr 0x3FFFE then 0x3FFFF; ready low for exactly 3 cycles.
